// File: rtl/cont_train_seq.sv
// Training sequencer for the continuous-bundling class memory.
// Turns a labelled stream of encoded training hypervectors into the memory
// control sequence for one class session. The sequence is a clear, then one
// enable per bundled sample, then a finish, then a wait for done.
// It also enforces a single label per session, caps the session at the
// bundler counter range, and times out a missing memory done.
module cont_train_seq #(
    parameter int DIMENSIONS   = 10000,
    parameter int COUNT_SIZE   = 8,
    parameter int DONE_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DIMENSIONS-1:0] s_hv,
    input  logic                  s_label,
    input  logic                  s_last,
    output logic                  mem_clr,
    output logic                  mem_en,
    output logic [DIMENSIONS-1:0] mem_hv,
    output logic                  mem_label,
    output logic                  mem_finish,
    input  logic                  mem_done,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic [COUNT_SIZE-1:0] sample_count,
    output logic [2:0]            dbg_state
);

    // Session capacity is the full range of the bundler counter.
    localparam logic [COUNT_SIZE-1:0] MAX_SAMPLES = '1;
    // Count value at which one more bundled sample fills the session.
    localparam logic [COUNT_SIZE-1:0] LAST_SLOT   = {{(COUNT_SIZE-1){1'b1}}, 1'b0};
    localparam int                    TW          = $clog2(DONE_TIMEOUT + 1);
    localparam logic [TW-1:0]         TIMEOUT_VAL = TW'(DONE_TIMEOUT);

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_LABEL    = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CLEAR     = 3'd1,
        S_ACCUM     = 3'd2,
        S_FINISH    = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [COUNT_SIZE-1:0]   count_q, count_d;
    logic                    err_q, err_d;
    logic [1:0]              code_q, code_d;
    logic                    label_q, label_d;
    logic                    have_label_q, have_label_d;
    logic                    en_q, en_d;
    logic [DIMENSIONS-1:0]   hv_q, hv_d;
    logic [TW-1:0]           wait_q, wait_d;

    logic abort_act;
    logic accept;
    logic label_ok;
    logic count_full;

    // Handshake: a sample transfers in exactly the cycles where s_valid and
    // s_ready are both high. s_ready is high only in ACCUM with no abort
    // pending, so an aborted cycle never swallows a sample.
    // s_ready does not wait for s_valid. The source must hold s_hv, s_label
    // and s_last stable while s_valid is high and s_ready is low.
    assign abort_act  = abort && (state_q != S_IDLE);
    assign s_ready    = (state_q == S_ACCUM) && !abort;
    assign accept     = s_valid && s_ready;
    assign label_ok   = !have_label_q || (s_label == label_q);
    assign count_full = (count_q == LAST_SLOT);

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = S_ACCUM;
            end
            S_ACCUM: begin
                // A mismatched last sample still closes the session.
                // Only a bundled sample can fill the counter.
                if (accept && (s_last || (label_ok && count_full))) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (mem_done || (wait_q == TIMEOUT_VAL)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort_act) begin
            state_d = S_IDLE;
        end
    end

    // Datapath next values. These are the sample bundling, the session
    // counters, and first-error capture.
    always_comb begin
        count_d      = count_q;
        err_d        = err_q;
        code_d       = code_q;
        label_d      = label_q;
        have_label_d = have_label_q;
        en_d         = 1'b0;
        hv_d         = hv_q;
        wait_d       = wait_q;
        if (!abort_act) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        count_d      = '0;
                        err_d        = 1'b0;
                        code_d       = ERR_NONE;
                        have_label_d = 1'b0;
                    end
                end
                S_ACCUM: begin
                    if (accept) begin
                        if (label_ok) begin
                            en_d    = 1'b1;
                            hv_d    = s_hv;
                            count_d = count_q + 1'b1;
                            if (!have_label_q) begin
                                label_d      = s_label;
                                have_label_d = 1'b1;
                            end
                            // Filling the counter without s_last is flagged.
                            // The session still closes normally.
                            if (count_full && !s_last) begin
                                err_d = 1'b1;
                                if (code_q == ERR_NONE) begin
                                    code_d = ERR_OVERFLOW;
                                end
                            end
                        end else begin
                            err_d = 1'b1;
                            if (code_q == ERR_NONE) begin
                                code_d = ERR_LABEL;
                            end
                        end
                    end
                end
                S_FINISH: begin
                    wait_d = '0;
                end
                S_WAIT_DONE: begin
                    wait_d = wait_q + 1'b1;
                    if (!mem_done && (wait_q == TIMEOUT_VAL)) begin
                        err_d = 1'b1;
                        if (code_q == ERR_NONE) begin
                            code_d = ERR_TIMEOUT;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; everything returns to zero on reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count_q      <= '0;
            err_q        <= 1'b0;
            code_q       <= ERR_NONE;
            label_q      <= 1'b0;
            have_label_q <= 1'b0;
            en_q         <= 1'b0;
            hv_q         <= '0;
            wait_q       <= '0;
        end else begin
            count_q      <= count_d;
            err_q        <= err_d;
            code_q       <= code_d;
            label_q      <= label_d;
            have_label_q <= have_label_d;
            en_q         <= en_d;
            hv_q         <= hv_d;
            wait_q       <= wait_d;
        end
    end

    // Control strobes. An abort cancels any enable or finish in flight.
    // It also clears the memory counters in that same cycle.
    always_comb begin
        mem_clr    = (state_q == S_CLEAR) || abort_act;
        mem_en     = en_q && !abort_act;
        mem_finish = (state_q == S_FINISH) && !abort_act;
        done       = (state_q == S_DONE) && !abort_act;
        busy       = (state_q != S_IDLE);
    end

    assign mem_hv       = hv_q;
    assign mem_label    = label_q;
    assign err          = err_q;
    assign err_code     = code_q;
    assign sample_count = count_q;
    assign dbg_state    = state_q;

    // MAX_SAMPLES documents the capacity that LAST_SLOT is derived from.
    logic unused_max;
    assign unused_max = &MAX_SAMPLES;

endmodule

// File: tb/tb_cont_train_seq.sv
// Directed bench for cont_train_seq. One instance uses default parameters.
// A second, narrow instance (COUNT_SIZE = 2) covers session overflow.
// Both instances share the same stimulus.
module tb_cont_train_seq;

    localparam int DIM  = 10000;
    localparam int DIM2 = 16;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic s_valid = 1'b0;
    logic s_label = 1'b0;
    logic s_last = 1'b0;
    logic mem_done = 1'b0;
    logic [DIM-1:0] s_hv = '0;

    logic           s_ready, mem_clr, mem_en, mem_label, mem_finish, busy, done, err;
    logic [DIM-1:0] mem_hv;
    logic [1:0]     err_code;
    logic [7:0]     sample_count;
    logic [2:0]     dbg_state;

    logic            s_ready2, mem_clr2, mem_en2, mem_label2, mem_finish2, busy2, done2, err2;
    logic [DIM2-1:0] mem_hv2;
    logic [1:0]      err_code2;
    logic [1:0]      sample_count2;
    logic [2:0]      dbg_state2;

    int n_vec = 0;
    int n_miss = 0;

    cont_train_seq dut (
        .clk(clk), .nrst(nrst), .start(start), .abort(abort),
        .s_valid(s_valid), .s_ready(s_ready), .s_hv(s_hv),
        .s_label(s_label), .s_last(s_last),
        .mem_clr(mem_clr), .mem_en(mem_en), .mem_hv(mem_hv),
        .mem_label(mem_label), .mem_finish(mem_finish), .mem_done(mem_done),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .sample_count(sample_count), .dbg_state(dbg_state)
    );

    cont_train_seq #(.DIMENSIONS(DIM2), .COUNT_SIZE(2), .DONE_TIMEOUT(16)) dut2 (
        .clk(clk), .nrst(nrst), .start(start), .abort(abort),
        .s_valid(s_valid), .s_ready(s_ready2), .s_hv(s_hv[DIM2-1:0]),
        .s_label(s_label), .s_last(s_last),
        .mem_clr(mem_clr2), .mem_en(mem_en2), .mem_hv(mem_hv2),
        .mem_label(mem_label2), .mem_finish(mem_finish2), .mem_done(mem_done),
        .busy(busy2), .done(done2), .err(err2), .err_code(err_code2),
        .sample_count(sample_count2), .dbg_state(dbg_state2)
    );

    // Clock generation
    always #5 clk = ~clk;

    // Event recorder: one bit per session-relative cycle, sampled mid-cycle.
    logic            mon_on = 1'b0;
    int              mon_cyc = 0;
    logic [63:0]     en_mask, acc_mask, clr_mask, fin_mask, done_mask;
    logic [63:0]     en2_mask, acc2_mask, fin2_mask, done2_mask;
    logic [DIM-1:0]  en_hv_q[$];
    logic [DIM2-1:0] en2_hv_q[$];

    always @(negedge clk) begin
        if (mon_on && mon_cyc < 64) begin
            if (mem_en) begin en_mask[mon_cyc] = 1'b1; en_hv_q.push_back(mem_hv); end
            if (s_valid && s_ready) acc_mask[mon_cyc] = 1'b1;
            if (mem_clr) clr_mask[mon_cyc] = 1'b1;
            if (mem_finish) fin_mask[mon_cyc] = 1'b1;
            if (done) done_mask[mon_cyc] = 1'b1;
            if (mem_en2) begin en2_mask[mon_cyc] = 1'b1; en2_hv_q.push_back(mem_hv2); end
            if (s_valid && s_ready2) acc2_mask[mon_cyc] = 1'b1;
            if (mem_finish2) fin2_mask[mon_cyc] = 1'b1;
            if (done2) done2_mask[mon_cyc] = 1'b1;
            mon_cyc = mon_cyc + 1;
        end
    end

    task automatic mon_start();
        en_mask = '0; acc_mask = '0; clr_mask = '0; fin_mask = '0; done_mask = '0;
        en2_mask = '0; acc2_mask = '0; fin2_mask = '0; done2_mask = '0;
        en_hv_q.delete();
        en2_hv_q.delete();
        mon_cyc = 0;
        mon_on = 1'b1;
    endtask

    // Driver tasks
    function automatic logic [DIM-1:0] rep(input logic [15:0] p);
        return {625{p}};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_idle();
        start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_label = 1'b0; s_last = 1'b0;
    endtask

    task automatic drive_sample(input logic [15:0] p, input logic lbl, input logic last);
        s_valid = 1'b1; s_hv = rep(p); s_label = lbl; s_last = last;
    endtask

    task automatic apply_reset();
        drive_idle();
        mem_done = 1'b0;
        mon_on = 1'b0;
        nrst = 1'b0;
        repeat (2) @(posedge clk);
        #2 nrst = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (s_ready !== 1'b0) begin n_miss++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
        n_vec++; if ({mem_clr, mem_en, mem_finish, done} !== 4'b0) begin n_miss++; $display("FAIL reset_strobes: got %b want 0000", {mem_clr, mem_en, mem_finish, done}); end
        n_vec++; if (mem_hv !== '0) begin n_miss++; $display("FAIL reset_mem_hv: got %h want 0 (low 16 bits)", mem_hv[15:0]); end
        n_vec++; if ({mem_label, err, err_code} !== 4'b0) begin n_miss++; $display("FAIL reset_label_err: got %b want 0000", {mem_label, err, err_code}); end
        n_vec++; if (sample_count !== 8'd0) begin n_miss++; $display("FAIL reset_count: got %0d want 0", sample_count); end
        n_vec++; if (dbg_state !== 3'd0) begin n_miss++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        apply_reset();
    endtask

    task automatic test_basic();
        logic [DIM-1:0] hv_a, hv_b, hv_c;
        hv_a = rep(16'h1A2B); hv_b = rep(16'h3C4D); hv_c = rep(16'h5E6F);
        apply_reset();
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            drive_idle();
            mem_done = (c == 7);
            if (c == 0) begin mon_start(); start = 1'b1; end
            if (c == 2) drive_sample(16'h1A2B, 1'b1, 1'b0);
            if (c == 3) drive_sample(16'h3C4D, 1'b1, 1'b0);
            if (c == 4) drive_sample(16'h5E6F, 1'b1, 1'b1);
        end
        #4;
        n_vec++; if (en_mask !== 64'h38) begin n_miss++; $display("FAIL basic_en_cycles: got %h want %h", en_mask, 64'h38); end
        n_vec++; if (en_hv_q.size() != 3 || en_hv_q[0] !== hv_a || en_hv_q[1] !== hv_b || en_hv_q[2] !== hv_c) begin
            n_miss++; $display("FAIL basic_en_data: got %0d beats want 3 carrying A,B,C", en_hv_q.size()); end
        n_vec++; if (clr_mask !== 64'h2) begin n_miss++; $display("FAIL basic_clr: got %h want %h", clr_mask, 64'h2); end
        n_vec++; if (fin_mask !== 64'h20) begin n_miss++; $display("FAIL basic_finish: got %h want %h", fin_mask, 64'h20); end
        n_vec++; if (done_mask !== 64'h100) begin n_miss++; $display("FAIL basic_done: got %h want %h", done_mask, 64'h100); end
        n_vec++; if (mem_label !== 1'b1) begin n_miss++; $display("FAIL basic_label: got %b want 1", mem_label); end
        n_vec++; if (sample_count !== 8'd3) begin n_miss++; $display("FAIL basic_count: got %0d want 3", sample_count); end
        n_vec++; if (err !== 1'b0 || err_code !== 2'd0) begin n_miss++; $display("FAIL basic_err: got %b/%0d want 0/0", err, err_code); end
        n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL basic_idle: got busy %b want 0", busy); end
    endtask

    task automatic test_valid_across_start();
        logic [DIM-1:0] hv_d, hv_e;
        hv_d = rep(16'hD00D); hv_e = rep(16'hE11E);
        apply_reset();
        mem_done = 1'b1;
        for (int c = 0; c < 9; c++) begin
            next_cycle();
            drive_idle();
            if (c == 0) begin mon_start(); start = 1'b1; end
            if (c <= 2) drive_sample(16'hD00D, 1'b0, 1'b0);
            if (c == 3) drive_sample(16'hE11E, 1'b0, 1'b1);
        end
        #4;
        n_vec++; if (acc_mask !== 64'hC) begin n_miss++; $display("FAIL vstart_accepts: got %h want %h", acc_mask, 64'hC); end
        n_vec++; if (clr_mask !== 64'h2) begin n_miss++; $display("FAIL vstart_clr: got %h want %h", clr_mask, 64'h2); end
        n_vec++; if (en_mask !== 64'h18) begin n_miss++; $display("FAIL vstart_en: got %h want %h", en_mask, 64'h18); end
        n_vec++; if (en_hv_q.size() != 2 || en_hv_q[0] !== hv_d || en_hv_q[1] !== hv_e) begin
            n_miss++; $display("FAIL vstart_en_data: got %0d beats want 2 carrying D,E", en_hv_q.size()); end
        n_vec++; if (fin_mask !== 64'h10) begin n_miss++; $display("FAIL vstart_finish: got %h want %h", fin_mask, 64'h10); end
        n_vec++; if (done_mask !== 64'h40) begin n_miss++; $display("FAIL vstart_done: got %h want %h", done_mask, 64'h40); end
    endtask

    task automatic test_label_mismatch();
        logic [DIM-1:0] f0, f1, f3;
        f0 = rep(16'hF000); f1 = rep(16'hF111); f3 = rep(16'hF333);
        apply_reset();
        mem_done = 1'b1;
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            drive_idle();
            if (c == 0) begin mon_start(); start = 1'b1; end
            if (c == 2) drive_sample(16'hF000, 1'b0, 1'b0);
            if (c == 3) drive_sample(16'hF111, 1'b0, 1'b0);
            if (c == 4) drive_sample(16'hF222, 1'b1, 1'b0);
            if (c == 5) drive_sample(16'hF333, 1'b0, 1'b1);
        end
        #4;
        n_vec++; if (acc_mask !== 64'h3C) begin n_miss++; $display("FAIL mism_accepts: got %h want %h", acc_mask, 64'h3C); end
        n_vec++; if (en_mask !== 64'h58) begin n_miss++; $display("FAIL mism_en: got %h want %h", en_mask, 64'h58); end
        n_vec++; if (en_hv_q.size() != 3 || en_hv_q[0] !== f0 || en_hv_q[1] !== f1 || en_hv_q[2] !== f3) begin
            n_miss++; $display("FAIL mism_en_data: got %0d beats want 3 carrying F0,F1,F3", en_hv_q.size()); end
        n_vec++; if (sample_count !== 8'd3) begin n_miss++; $display("FAIL mism_count: got %0d want 3", sample_count); end
        n_vec++; if (err !== 1'b1 || err_code !== 2'd1) begin n_miss++; $display("FAIL mism_err: got %b/%0d want 1/1", err, err_code); end
        n_vec++; if (mem_label !== 1'b0) begin n_miss++; $display("FAIL mism_label: got %b want 0", mem_label); end
        n_vec++; if (done_mask !== 64'h100) begin n_miss++; $display("FAIL mism_done: got %h want %h", done_mask, 64'h100); end
    endtask

    task automatic test_overflow();
        logic [15:0] g[5];
        g[0] = 16'hA0A0; g[1] = 16'hA1A1; g[2] = 16'hA2A2; g[3] = 16'hA3A3; g[4] = 16'hA4A4;
        apply_reset();
        mem_done = 1'b1;
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            drive_idle();
            if (c == 0) begin mon_start(); start = 1'b1; end
            if (c >= 2 && c <= 6) drive_sample(g[c-2], 1'b1, 1'b0);
            if (c == 5) begin
                #1;
                n_vec++; if (s_ready2 !== 1'b0) begin n_miss++; $display("FAIL ovf_ready_fall: got %b want 0", s_ready2); end
            end
        end
        #4;
        n_vec++; if (acc2_mask !== 64'h1C) begin n_miss++; $display("FAIL ovf_accepts: got %h want %h", acc2_mask, 64'h1C); end
        n_vec++; if (fin2_mask !== 64'h20) begin n_miss++; $display("FAIL ovf_finish: got %h want %h", fin2_mask, 64'h20); end
        n_vec++; if (en2_mask !== 64'h38) begin n_miss++; $display("FAIL ovf_en: got %h want %h", en2_mask, 64'h38); end
        n_vec++; if (en2_hv_q.size() != 3 || en2_hv_q[0] !== g[0] || en2_hv_q[1] !== g[1] || en2_hv_q[2] !== g[2]) begin
            n_miss++; $display("FAIL ovf_en_data: got %0d beats want 3 carrying G0..G2", en2_hv_q.size()); end
        n_vec++; if (sample_count2 !== 2'd3) begin n_miss++; $display("FAIL ovf_count: got %0d want 3", sample_count2); end
        n_vec++; if (err2 !== 1'b1 || err_code2 !== 2'd2) begin n_miss++; $display("FAIL ovf_err: got %b/%0d want 1/2", err2, err_code2); end
        n_vec++; if (done2_mask !== 64'h80) begin n_miss++; $display("FAIL ovf_done: got %h want %h", done2_mask, 64'h80); end
    endtask

    task automatic test_first_error();
        apply_reset();
        mem_done = 1'b1;
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            drive_idle();
            if (c == 0) begin mon_start(); start = 1'b1; end
            if (c == 2) drive_sample(16'hB0B0, 1'b1, 1'b0);
            if (c == 3) drive_sample(16'hB1B1, 1'b0, 1'b0);
            if (c == 4) drive_sample(16'hB2B2, 1'b1, 1'b0);
            if (c == 5) drive_sample(16'hB3B3, 1'b1, 1'b0);
        end
        #4;
        n_vec++; if (en2_mask !== 64'h68) begin n_miss++; $display("FAIL ferr_en: got %h want %h", en2_mask, 64'h68); end
        n_vec++; if (fin2_mask !== 64'h40) begin n_miss++; $display("FAIL ferr_finish: got %h want %h", fin2_mask, 64'h40); end
        n_vec++; if (err2 !== 1'b1 || err_code2 !== 2'd1) begin n_miss++; $display("FAIL ferr_code: got %b/%0d want 1/1", err2, err_code2); end
        n_vec++; if (sample_count2 !== 2'd3) begin n_miss++; $display("FAIL ferr_count: got %0d want 3", sample_count2); end
        n_vec++; if (done2_mask !== 64'h100) begin n_miss++; $display("FAIL ferr_done: got %h want %h", done2_mask, 64'h100); end
    endtask

    task automatic test_timeout();
        apply_reset();
        mem_done = 1'b0;
        for (int c = 0; c < 25; c++) begin
            next_cycle();
            drive_idle();
            if (c == 0) begin mon_start(); start = 1'b1; end
            if (c == 2) drive_sample(16'h7777, 1'b0, 1'b1);
        end
        #4;
        n_vec++; if (fin_mask !== 64'h8) begin n_miss++; $display("FAIL tmo_finish: got %h want %h", fin_mask, 64'h8); end
        n_vec++; if (done_mask !== 64'h200000) begin n_miss++; $display("FAIL tmo_done: got %h want %h", done_mask, 64'h200000); end
        n_vec++; if (err !== 1'b1 || err_code !== 2'd3) begin n_miss++; $display("FAIL tmo_err: got %b/%0d want 1/3", err, err_code); end
        n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL tmo_idle: got busy %b want 0", busy); end
    endtask

    task automatic test_abort_restart();
        apply_reset();
        mem_done = 1'b1;
        for (int c = 0; c < 15; c++) begin
            next_cycle();
            drive_idle();
            if (c == 0) begin mon_start(); start = 1'b1; end
            if (c == 2) drive_sample(16'hC0C0, 1'b1, 1'b0);
            if (c == 3) drive_sample(16'hC1C1, 1'b1, 1'b0);
            if (c == 4) begin drive_sample(16'hC2C2, 1'b1, 1'b0); abort = 1'b1; end
            if (c == 5 || c == 6) begin
                #1;
                n_vec++; if (sample_count !== 8'd2 || busy !== 1'b0) begin
                    n_miss++; $display("FAIL abort_hold: cycle %0d got count %0d busy %b want 2/0", c, sample_count, busy); end
            end
            if (c == 7) start = 1'b1;
            if (c == 8) begin
                #1;
                n_vec++; if (sample_count !== 8'd0) begin n_miss++; $display("FAIL abort_restart_clear: got %0d want 0", sample_count); end
            end
            if (c == 9) drive_sample(16'hC9C9, 1'b0, 1'b1);
        end
        #4;
        n_vec++; if (acc_mask !== 64'h20C) begin n_miss++; $display("FAIL abort_accepts: got %h want %h", acc_mask, 64'h20C); end
        n_vec++; if (en_mask !== 64'h408) begin n_miss++; $display("FAIL abort_en: got %h want %h", en_mask, 64'h408); end
        n_vec++; if (clr_mask !== 64'h112) begin n_miss++; $display("FAIL abort_clr: got %h want %h", clr_mask, 64'h112); end
        n_vec++; if (fin_mask !== 64'h400) begin n_miss++; $display("FAIL abort_finish: got %h want %h", fin_mask, 64'h400); end
        n_vec++; if (done_mask !== 64'h1000) begin n_miss++; $display("FAIL abort_done: got %h want %h", done_mask, 64'h1000); end
        n_vec++; if (sample_count !== 8'd1 || mem_label !== 1'b0 || err !== 1'b0) begin
            n_miss++; $display("FAIL abort_new_session: got count %0d label %b err %b want 1/0/0", sample_count, mem_label, err); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        mem_done = 1'b0;
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            drive_idle();
            if (c == 0) start = 1'b1;
            if (c == 2) drive_sample(16'h4242, 1'b1, 1'b0);
            if (c == 3) drive_sample(16'h4343, 1'b1, 1'b0);
        end
        #1;
        n_vec++; if (mem_en !== 1'b1 || busy !== 1'b1) begin n_miss++; $display("FAIL areset_pre: got en %b busy %b want 1/1", mem_en, busy); end
        #1 nrst = 1'b0;
        #1;
        n_vec++; if ({busy, s_ready, mem_en, mem_clr, mem_label} !== 5'b0) begin
            n_miss++; $display("FAIL areset_ctrl: got %b want 00000", {busy, s_ready, mem_en, mem_clr, mem_label}); end
        n_vec++; if (mem_hv !== '0 || sample_count !== 8'd0 || dbg_state !== 3'd0) begin
            n_miss++; $display("FAIL areset_data: got hv %h count %0d state %0d want 0/0/0", mem_hv[15:0], sample_count, dbg_state); end
        drive_idle();
        #3 nrst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_valid_across_start();
        test_label_mismatch();
        test_overflow();
        test_first_error();
        test_timeout();
        test_abort_restart();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
